// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment driver:
//   - GLYPH_0 .. GLYPH_F : active-low segment patterns, bit order g..a
//   - SEG_OFF            : all segments dark
//   - scan_state_e       : scan FSM states (GUARD = dead time, DRIVE = digit lit)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Purely combinational hex nibble to seven-segment glyph lookup.
// Ports:
//   nibble_i [3:0] : hex digit 0..F
//   seg_o    [6:0] : active-low segments, bit order g..a
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed N-digit hex seven-segment driver for common-anode displays.
// Each digit owns a SCAN_DIV-cycle slot: GUARD_CYC dark cycles (anti-ghosting)
// followed by SCAN_DIV-GUARD_CYC cycles with the digit enabled. New values are
// captured into a pending set on in_load and only become visible at the frame
// wrap, so a frame never shows a mix of old and new data.
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   in_value   : 4*NUM_DIGITS hex nibbles, nibble k -> digit k (digit 0 = LSB)
//   in_dp      : per-digit decimal point request
//   in_blank   : per-digit force-dark
//   in_load    : one-cycle strobe capturing in_value/in_dp/in_blank
//   out_seg    : segments g..a, active-low
//   out_dp     : decimal point, active-low
//   out_dig    : one-hot digit enable (low-true when DIG_ACTIVE_LOW = 1)
//   out_frame  : one-cycle pulse when the scan wraps from the last digit to 0
//
// Build option:
//   SEG_LZ_SUPPRESS_EN : when defined, leading zero digits (MSB downward) are
//                        blanked as the display set is loaded; digit 0 is never
//                        suppressed and a set decimal point ends suppression.
// -----------------------------------------------------------------------------
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD_CYC      = 16,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic [NUM_DIGITS-1:0]   in_blank,
    input  logic                    in_load,
    output logic [6:0]              out_seg,
    output logic                    out_dp,
    output logic [NUM_DIGITS-1:0]   out_dig,
    output logic                    out_frame
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - GUARD_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    // Level on out_dig that leaves every digit disabled.
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    // ---------------------------------------------------------------- state
    scan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wrap;

    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_valid_q, pend_valid_d;

    logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
    // Stays low until the first pending set has been applied, so the display
    // is dark (not "0000") out of reset.
    logic                    disp_valid_q, disp_valid_d;

    logic [6:0]            out_seg_q, out_seg_d;
    logic                  out_dp_q, out_dp_d;
    logic [NUM_DIGITS-1:0] out_dig_q, out_dig_d;
    logic                  out_frame_q, out_frame_d;

    // ------------------------------------------------------ per-digit helpers
    logic [3:0]            disp_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dig_onehot;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [6:0]            dec_seg;

`ifdef SEG_LZ_SUPPRESS_EN
    // pend_zero[k]: digit k of the pending set is a zero with no decimal point.
    logic [NUM_DIGITS-1:1] pend_zero;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            // Outputs are computed from next-state values so that the
            // registered segments line up with the registered digit enable.
            assign disp_nib[gi]   = disp_value_d[4*gi +: 4];
            assign dig_onehot[gi] = (idx_d == IW'(gi));
`ifdef SEG_LZ_SUPPRESS_EN
            if (gi == 0) begin : g_lsd
                assign lz_mask[gi] = 1'b0;
            end else begin : g_upper
                assign pend_zero[gi] = (pend_value_q[4*gi +: 4] == 4'h0) && !pend_dp_q[gi];
                // Suppressed only if this digit and every digit above it is a
                // plain zero.
                assign lz_mask[gi]   = &pend_zero[NUM_DIGITS-1:gi];
            end
`else
            assign lz_mask[gi] = 1'b0;
`endif
        end
    endgenerate

    assign cur_nibble = disp_nib[idx_d];
    assign cur_blank  = disp_blank_d[idx_d];
    assign cur_dp     = disp_dp_d[idx_d];

    seg_hex_decode u_hex_decode (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

    // ---------------------------------------------------- scan FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------- load path
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        disp_value_d = disp_value_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        disp_valid_d = disp_valid_q;

        // The wrap always consumes the pending set held before this edge; a
        // load in the same cycle lands in pending for the following frame.
        if (wrap && pend_valid_q) begin
            disp_value_d = pend_value_q;
            disp_dp_d    = pend_dp_q;
            disp_blank_d = pend_blank_q | lz_mask;
            disp_valid_d = 1'b1;
        end

        if (in_load) begin
            pend_value_d = in_value;
            pend_dp_d    = in_dp;
            pend_blank_d = in_blank;
            pend_valid_d = 1'b1;
        end else if (wrap) begin
            pend_valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------- output stage
    always_comb begin
        out_seg_d   = SEG_OFF;
        out_dp_d    = 1'b1;
        out_dig_d   = DIG_OFF;
        out_frame_d = wrap;
        if (state_d == DRIVE) begin
            // Blanked digits still receive their enable so slot timing is
            // identical for every digit.
            out_dig_d = dig_onehot ^ DIG_OFF;
            if (disp_valid_d && !cur_blank) begin
                out_seg_d = dec_seg;
                out_dp_d  = ~cur_dp;
            end
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= GUARD;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            disp_valid_q <= 1'b0;
            out_seg_q    <= SEG_OFF;
            out_dp_q     <= 1'b1;
            out_dig_q    <= DIG_OFF;
            out_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            disp_value_q <= disp_value_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            disp_valid_q <= disp_valid_d;
            out_seg_q    <= out_seg_d;
            out_dp_q     <= out_dp_d;
            out_dig_q    <= out_dig_d;
            out_frame_q  <= out_frame_d;
        end
    end

    assign out_seg   = out_seg_q;
    assign out_dp    = out_dp_q;
    assign out_dig   = out_dig_q;
    assign out_frame = out_frame_q;

endmodule
